// File: rtl/ex_pkg.sv
// Shared definitions for the execute-stage iterative unit:
// widths, funct codes and FSM state encoding.
package ex_pkg;

    localparam int DEF_W   = 32;
    localparam int DEF_RDW = 5;
    localparam int DEF_PCW = 8;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_MULT = 6'h18;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MULT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ex_iter_unit_if.sv
// ID/EX operand bundle in, EX/MEM result bundle out,
// each side with its own valid/ready pair.
interface ex_iter_unit_if import ex_pkg::*; #(
    parameter int W   = DEF_W,
    parameter int RDW = DEF_RDW,
    parameter int PCW = DEF_PCW
);
    logic [W-1:0]   data1_EX;
    logic [W-1:0]   data2_EX;
    logic [W-1:0]   funct_EX;
    logic [RDW-1:0] rd_EX;
    logic [4:0]     shamt_EX;
    logic [PCW-1:0] nextIns_EX;
    logic           inValid_EX;
    logic           inReady_EX;
    logic [W-1:0]   result_EX;
    logic [RDW-1:0] rdOut_EX;
    logic [PCW-1:0] nextInsOut_EX;
    logic           illegal_EX;
    logic           outValid_EX;
    logic           outReady_EX;

    modport master (
        output data1_EX, data2_EX, funct_EX, rd_EX,
        output shamt_EX, nextIns_EX, inValid_EX, outReady_EX,
        input  inReady_EX, result_EX, rdOut_EX,
        input  nextInsOut_EX, illegal_EX, outValid_EX
    );

    modport slave (
        input  data1_EX, data2_EX, funct_EX, rd_EX,
        input  shamt_EX, nextIns_EX, inValid_EX, outReady_EX,
        output inReady_EX, result_EX, rdOut_EX,
        output nextInsOut_EX, illegal_EX, outValid_EX
    );

endinterface

// File: rtl/ex_mult_seq.sv
// Sign-magnitude shift-add multiplier: one partial product per
// cycle, W cycles after start; done/product valid in the last one.
module ex_mult_seq import ex_pkg::*; #(
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);
    localparam int CW = $clog2(W);

    logic           busy;
    logic           neg;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] sum;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;

    assign mag_a = a[W-1] ? -a : a;
    assign mag_b = b[W-1] ? -b : b;

    assign sum     = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && (cnt == CW'(W - 1));
    assign product = neg ? -sum : sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            neg    <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            neg    <= a[W-1] ^ b[W-1];
            cnt    <= '0;
            mcand  <= {{W{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
        end else if (busy) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_iter_unit.sv
// Execute stage: single-cycle ALU, 1-bit/cycle shifter and an
// iterative signed multiply into HI/LO, valid/ready on both sides.
module ex_iter_unit import ex_pkg::*; #(
    parameter int W   = DEF_W,
    parameter int RDW = DEF_RDW,
    parameter int PCW = DEF_PCW
) (
    input logic clk_EX,
    input logic rst_n_EX,
    ex_iter_unit_if.slave bus
);
    state_t         state;
    state_t         state_nx;
    logic [5:0]     f;
    logic [5:0]     op;
    logic [4:0]     cnt;
    logic [W-1:0]   d1;
    logic [W-1:0]   d2;
    logic [W-1:0]   alu_res;
    logic [W-1:0]   result;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic [RDW-1:0] rd_q;
    logic [PCW-1:0] nins_q;
    logic           illegal_q;
    logic           legal;
    logic           is_shift;
    logic           accept;
    logic           m_start;
    logic           m_done;
    logic [2*W-1:0] m_prod;

    function automatic logic [W-1:0] shift1(
        input logic [5:0]   k,
        input logic [W-1:0] v
    );
        logic [W-1:0] r;
        r = {v[W-1], v[W-1:1]};
        if (k == F_SLL)
            r = v << 1;
        else if (k == F_SRL)
            r = v >> 1;
        return r;
    endfunction

    assign f        = bus.funct_EX[5:0];
    assign d1       = bus.data1_EX;
    assign d2       = bus.data2_EX;
    assign accept   = bus.inValid_EX && bus.inReady_EX;
    assign is_shift = (f == F_SLL) || (f == F_SRL) || (f == F_SRA);
    assign m_start  = accept && (f == F_MULT);

    // Shifts perform their first bit on the accept edge so latency
    // is max(1, shamt); mult only arms the multiplier here.
    always_comb begin
        alu_res = '0;
        legal   = 1'b1;
        case (f)
            F_ADD, F_ADDU: alu_res = d1 + d2;
            F_SUB, F_SUBU: alu_res = d1 - d2;
            F_AND:         alu_res = d1 & d2;
            F_OR:          alu_res = d1 | d2;
            F_XOR:         alu_res = d1 ^ d2;
            F_NOR:         alu_res = ~(d1 | d2);
            F_SLT:         alu_res = W'($signed(d1) < $signed(d2));
            F_SLTU:        alu_res = W'(d1 < d2);
            F_MFHI:        alu_res = hi;
            F_MFLO:        alu_res = lo;
            F_SLL, F_SRL, F_SRA:
                alu_res = (bus.shamt_EX == 5'd0) ? d2 : shift1(f, d2);
            F_MULT:        alu_res = '0;
            default:       legal   = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (f == F_MULT)
                        state_nx = MULT;
                    else if (is_shift && bus.shamt_EX > 5'd1)
                        state_nx = SHIFT;
                    else
                        state_nx = DONE;
                end
            end
            SHIFT: if (cnt == 5'd1) state_nx = DONE;
            MULT:  if (m_done) state_nx = DONE;
            DONE:  if (bus.outReady_EX) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_EX or negedge rst_n_EX) begin
        if (!rst_n_EX)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk_EX or negedge rst_n_EX) begin
        if (!rst_n_EX) begin
            op        <= '0;
            cnt       <= '0;
            result    <= '0;
            hi        <= '0;
            lo        <= '0;
            rd_q      <= '0;
            nins_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                op        <= f;
                cnt       <= bus.shamt_EX - 5'd1;
                result    <= alu_res;
                rd_q      <= bus.rd_EX;
                nins_q    <= bus.nextIns_EX;
                illegal_q <= ~legal;
            end
            if (state == SHIFT) begin
                result <= shift1(op, result);
                cnt    <= cnt - 5'd1;
            end
            if (state == MULT && m_done) begin
                hi     <= m_prod[2*W-1:W];
                lo     <= m_prod[W-1:0];
                result <= m_prod[W-1:0];
            end
        end
    end

    ex_mult_seq #(.W(W)) u_mult (
        .clk     (clk_EX),
        .rst_n   (rst_n_EX),
        .start   (m_start),
        .a       (d1),
        .b       (d2),
        .done    (m_done),
        .product (m_prod)
    );

    assign bus.inReady_EX    = (state == IDLE);
    assign bus.outValid_EX   = (state == DONE);
    assign bus.result_EX     = result;
    assign bus.rdOut_EX      = rd_q;
    assign bus.nextInsOut_EX = nins_q;
    assign bus.illegal_EX    = illegal_q;

endmodule

// File: tb/tb_ex_iter_unit.sv
// Scoreboard bench for ex_iter_unit: directed cases then random
// traffic against an arithmetic reference model.
module tb_ex_iter_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_iter_unit_if bus ();

    ex_iter_unit dut (
        .clk_EX   (clk),
        .rst_n_EX (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic [7:0]  ni;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          bp = 2;
    bit          seen = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, expv, $time);
        end
    endtask

    function automatic exp_t model(input logic [5:0] f,
                                   input logic [31:0] a, b,
                                   input logic [4:0] sa,
                                   input logic [4:0] rd,
                                   input logic [7:0] ni);
        exp_t e;
        logic [63:0] p;
        e.res = '0; e.rd = rd; e.ni = ni; e.ill = 1'b0;
        e.lat = 1; e.acc = 0;
        case (f)
            6'h20, 6'h21: e.res = a + b;
            6'h22, 6'h23: e.res = a - b;
            6'h24: e.res = a & b;
            6'h25: e.res = a | b;
            6'h26: e.res = a ^ b;
            6'h27: e.res = ~(a | b);
            6'h2A: e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6'h2B: e.res = (a < b) ? 32'd1 : 32'd0;
            6'h10: e.res = m_hi;
            6'h12: e.res = m_lo;
            6'h00: e.res = b << sa;
            6'h02: e.res = b >> sa;
            6'h03: e.res = 32'($signed(b) >>> sa);
            6'h18: begin
                p = 64'(longint'(int'(a)) * longint'(int'(b)));
                m_hi = p[63:32];
                m_lo = p[31:0];
                e.res = p[31:0];
                e.lat = 33;
            end
            default: e.ill = 1'b1;
        endcase
        if (f == 6'h00 || f == 6'h02 || f == 6'h03)
            e.lat = (sa == 5'd0) ? 1 : int'(sa);
        return e;
    endfunction

    task automatic drive(input logic [5:0] f, input logic [31:0] a, b,
                         input logic [4:0] sa, input logic [4:0] rd,
                         input logic [7:0] ni);
        bus.data1_EX   = a;
        bus.data2_EX   = b;
        bus.funct_EX   = {{26{f[5]}}, f};
        bus.shamt_EX   = sa;
        bus.rd_EX      = rd;
        bus.nextIns_EX = ni;
        bus.inValid_EX = 1'b1;
    endtask

    task automatic send(input logic [5:0] f, input logic [31:0] a, b,
                        input logic [4:0] sa, input logic [4:0] rd,
                        input logic [7:0] ni);
        exp_t e;
        bit   ok = 0;
        bit   rdy;
        int   edge_n = 0;
        e = model(f, a, b, sa, rd, ni);
        @(negedge clk);
        drive(f, a, b, sa, rd, ni);
        for (int w = 0; w < 300; w++) begin
            rdy = bus.inReady_EX;
            edge_n = cyc + 1;
            @(posedge clk);
            if (rdy) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: funct %0h never accepted", f);
        end else begin
            e.acc = edge_n;
            q.push_back(e);
        end
        #1 bus.inValid_EX = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 800) begin
            @(posedge clk);
            n++;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding", q.size());
        end
    endtask

    // Outputs are compared every cycle they are valid, which also
    // catches any change while the result is held by backpressure.
    always @(negedge clk) begin
        if (rst_n && bus.outValid_EX) begin
            if (q.size() == 0) begin
                chk("spurious_out", 64'(bus.outValid_EX), 64'd0);
            end else begin
                if (!seen) begin
                    chk("latency", 64'(cyc), 64'(q[0].acc + q[0].lat - 1));
                    seen = 1;
                end
                chk("result", 64'(bus.result_EX), 64'(q[0].res));
                chk("rd", 64'(bus.rdOut_EX), 64'(q[0].rd));
                chk("nextins", 64'(bus.nextInsOut_EX), 64'(q[0].ni));
                chk("illegal", 64'(bus.illegal_EX), 64'(q[0].ill));
                chk("inready_done", 64'(bus.inReady_EX), 64'd0);
                if (bus.outReady_EX) begin
                    void'(q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp == 0)
                bus.outReady_EX = ($urandom_range(0, 3) != 0);
            else
                bus.outReady_EX = (bp == 2);
        end
    end

    logic [5:0] ops [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                             6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                             6'h10, 6'h12, 6'h00, 6'h18};
    logic [5:0] bad [4] = '{6'h3F, 6'h01, 6'h11, 6'h30};

    function automatic logic [31:0] rnd_data();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0: v = 32'h8000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [5:0] f;
        bus.data1_EX = '0; bus.data2_EX = '0; bus.funct_EX = '0;
        bus.shamt_EX = '0; bus.rd_EX = '0; bus.nextIns_EX = '0;
        bus.inValid_EX = 1'b0; bus.outReady_EX = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rst_outvalid", 64'(bus.outValid_EX), 64'd0);
        chk("rst_inready", 64'(bus.inReady_EX), 64'd1);
        chk("rst_result", 64'(bus.result_EX), 64'd0);
        chk("rst_rd", 64'(bus.rdOut_EX), 64'd0);
        chk("rst_nextins", 64'(bus.nextInsOut_EX), 64'd0);
        chk("rst_illegal", 64'(bus.illegal_EX), 64'd0);

        send(6'h20, 32'hFFFF_FFFF, 32'd2, 5'd0, 5'd17, 8'h44);
        send(6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd17, 8'h44);
        send(6'h2B, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd17, 8'h44);
        send(6'h27, 32'd0, 32'd0, 5'd0, 5'd17, 8'h44);
        send(6'h03, 32'd0, 32'h8000_0000, 5'd4, 5'd3, 8'h10);
        send(6'h02, 32'd0, 32'h8000_0000, 5'd4, 5'd3, 8'h11);
        send(6'h00, 32'd0, 32'h1, 5'd0, 5'd3, 8'h12);
        send(6'h00, 32'd0, 32'h1, 5'd31, 5'd3, 8'h13);
        send(6'h18, -32'sd3, 32'd5, 5'd0, 5'd9, 8'h20);
        send(6'h10, 32'd0, 32'd0, 5'd0, 5'd9, 8'h21);
        send(6'h12, 32'd0, 32'd0, 5'd0, 5'd9, 8'h22);
        send(6'h18, 32'h8000_0000, 32'h8000_0000, 5'd0, 5'd1, 8'h23);
        send(6'h10, 32'd0, 32'd0, 5'd0, 5'd1, 8'h24);
        send(6'h12, 32'd0, 32'd0, 5'd0, 5'd1, 8'h25);
        send(6'h3F, 32'd5, 32'd6, 5'd0, 5'd2, 8'h26);
        send(6'h21, 32'd5, 32'd6, 5'd0, 5'd2, 8'h27);
        drain();

        send(6'h18, 32'd7, 32'd9, 5'd0, 5'd4, 8'h30);
        void'(q.pop_front());
        m_hi = '0;
        m_lo = '0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outvalid", 64'(bus.outValid_EX), 64'd0);
        chk("midrst_result", 64'(bus.result_EX), 64'd0);
        chk("midrst_rd", 64'(bus.rdOut_EX), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("midrst_inready", 64'(bus.inReady_EX), 64'd1);
        repeat (40) @(posedge clk);
        send(6'h10, 32'd0, 32'd0, 5'd0, 5'd5, 8'h31);
        send(6'h12, 32'd0, 32'd0, 5'd0, 5'd5, 8'h32);
        drain();

        bp = 1;
        fork
            begin
                send(6'h25, 32'hF0, 32'h0F, 5'd0, 5'd6, 8'h40);
                send(6'h26, 32'hFF, 32'h0F, 5'd0, 5'd7, 8'h41);
            end
            begin
                repeat (7) @(posedge clk);
                bp = 2;
            end
        join
        drain();

        bp = 0;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 15) == 0)
                f = bad[$urandom_range(0, 3)];
            else
                f = ops[$urandom_range(0, 13)];
            if (f == 6'h00 && $urandom_range(0, 1) == 1)
                f = ($urandom_range(0, 1) == 1) ? 6'h02 : 6'h03;
            send(f, rnd_data(), rnd_data(), 5'($urandom_range(0, 31)),
                 5'($urandom), 8'($urandom));
        end
        bp = 2;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
